// File: rtl/memory_pkg.sv
// Shared defaults and request-type encoding for the word-addressed register memory.
package memory_pkg;

  localparam int MEM_WIDTH = 16;
  localparam int MEM_DEPTH = 64;

  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

endpackage : memory_pkg

// File: rtl/memory_if.sv
// Request/response bundle for the memory block; clk and rst travel separately.
interface memory_if
  import memory_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
);

  logic                  valid;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;

  modport master (
    output valid, wr_rd, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  valid, wr_rd, addr, wdata,
    output rdata, ready
  );

endinterface : memory_if

// File: rtl/memory.sv
// Single-stage registered memory: one request per cycle, 1-cycle read latency,
// whole array cleared asynchronously on reset.
module memory
  import memory_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ready
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             in_range;
  logic             wr_en;

  // An unknown wr_rd falls through to the read branch, so it can never write.
  always_comb begin
    in_range = (32'(addr) < 32'(DEPTH));
    wr_en    = 1'b0;
    rdata_d  = rdata_q;
    ready_d  = valid;
    if (valid) begin
      if (wr_rd == WRITE) begin
        wr_en = in_range;
      end else begin
        rdata_d = in_range ? mem_q[addr] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;

endmodule : memory

// File: tb/tb_memory.sv
// Directed bench for memory: reset, full write/read sweeps, hazards, async reset, idle.
module tb_memory;
  import memory_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  memory_if #(.WIDTH(16), .ADDR_WIDTH(6)) bus ();

  memory #(.WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (bus.valid),
    .wr_rd (bus.wr_rd),
    .addr  (bus.addr),
    .wdata (bus.wdata),
    .rdata (bus.rdata),
    .ready (bus.ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request and advance to just after the edge that samples it.
  task automatic drive(input logic v, input logic w, input logic [5:0] a, input logic [15:0] d);
    bus.valid = v;
    bus.wr_rd = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] final_exp(input int a);
    if (a == 3) return 16'h0BEE;
    if (a == 7) return 16'hC0DE;
    return 16'h0000;
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.valid = 1'b0;
    bus.wr_rd = READ;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset for two cycles
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_rdata", 32'(bus.rdata), 32'h0);
    check("reset_ready", 32'(bus.ready), 32'h0);
    rst = 1'b0;

    // Every address reads zero; first request accepted on first edge
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, READ, 6'(i), 16'h0);
      check("rst_read_data", 32'(bus.rdata), 32'h0);
      check("rst_read_ready", 32'(bus.ready), 32'h1);
    end
    drive(1'b0, READ, 6'h0, 16'h0);
    check("idle_ready0", 32'(bus.ready), 32'h0);

    // Full write sweep; rdata must not move on writes
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, WRITE, 6'(i), 16'hA000 + 16'(i));
      check("wr_sweep_ready", 32'(bus.ready), 32'h1);
      check("wr_sweep_rdata", 32'(bus.rdata), 32'h0);
    end
    drive(1'b0, READ, 6'h0, 16'h0);
    check("wr_sweep_ready_drop", 32'(bus.ready), 32'h0);

    // Full read-back sweep
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, READ, 6'(i), 16'h0);
      check("rd_sweep_data", 32'(bus.rdata), 32'hA000 + 32'(i));
      check("rd_sweep_ready", 32'(bus.ready), 32'h1);
    end

    // Write then immediate read of the same address
    drive(1'b1, WRITE, 6'd5, 16'h1234);
    check("raw_wr_hold", 32'(bus.rdata), 32'hA03F);
    drive(1'b1, READ, 6'd5, 16'h0);
    check("raw_rd_data", 32'(bus.rdata), 32'h1234);
    check("raw_rd_ready", 32'(bus.ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, READ, 6'd9, 16'hDEAD);
      check("idle_hold_data", 32'(bus.rdata), 32'h1234);
      check("idle_hold_ready", 32'(bus.ready), 32'h0);
    end

    // Async reset between edges with a write in flight
    drive(1'b1, WRITE, 6'd10, 16'hFFFF);
    drive(1'b1, READ, 6'd10, 16'h0);
    check("pre_rst_data", 32'(bus.rdata), 32'hFFFF);
    bus.valid = 1'b1;
    bus.wr_rd = WRITE;
    bus.addr  = 6'd10;
    bus.wdata = 16'h5555;
    #2 rst = 1'b1;
    #1;
    check("async_rst_rdata", 32'(bus.rdata), 32'h0);
    check("async_rst_ready", 32'(bus.ready), 32'h0);
    @(posedge clk);
    #1;
    check("rst_held_ready", 32'(bus.ready), 32'h0);
    rst = 1'b0;
    drive(1'b1, READ, 6'd10, 16'h0);
    check("post_rst_a10", 32'(bus.rdata), 32'h0);
    check("post_rst_ready", 32'(bus.ready), 32'h1);
    drive(1'b1, READ, 6'd11, 16'h0);
    check("post_rst_a11", 32'(bus.rdata), 32'h0);

    // Idle with toggling don't-care inputs must not disturb memory
    drive(1'b1, WRITE, 6'd3, 16'h0BEE);
    drive(1'b1, WRITE, 6'd7, 16'hC0DE);
    drive(1'b1, READ, 6'd7, 16'h0);
    check("pre_idle_data", 32'(bus.rdata), 32'hC0DE);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'(i), 6'(i * 7), 16'($urandom));
      check("toggle_ready", 32'(bus.ready), 32'h0);
      check("toggle_rdata", 32'(bus.rdata), 32'hC0DE);
    end
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, READ, 6'(i), 16'h0);
      check("final_sweep", 32'(bus.rdata), 32'(final_exp(i)));
    end
    drive(1'b0, READ, 6'h0, 16'h0);
    check("final_ready0", 32'(bus.ready), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_memory
